// File: rtl/full_adder.sv
// full_adder: single-bit full adder with a combinational result and a
// registered, valid-qualified copy, plus a wrapping carry-event counter.
//
// Ports:
//   clk        - clock; all registers update on the rising edge
//   rst        - synchronous, active-high reset
//   a, b, ci   - operands and carry-in
//   sum, carry - combinational result, {carry, sum} = a + b + ci
//   in_valid   - qualifies a, b, ci for the registered path
//   sum_q      - registered sum (holds when in_valid = 0)
//   carry_q    - registered carry (holds when in_valid = 0)
//   out_valid  - sum_q / carry_q were loaded on the last edge
//   carry_cnt  - number of qualified operations with carry = 1, mod 2^CNT_W
module full_adder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             ci,
    output logic             sum,
    output logic             carry,
    input  logic             in_valid,
    output logic             sum_q,
    output logic             carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    // Pure function of the inputs; unaffected by rst and in_valid.
    always_comb begin
        sum   = a ^ b ^ ci;
        carry = (a & b) | (a & ci) | (b & ci);
    end

    // Reset wins over in_valid, so a qualified input on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
                if (carry) begin
                    carry_cnt <= carry_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, ci;
    logic       sum, carry;
    logic       in_valid;
    logic       sum_q, carry_q, out_valid;
    logic [7:0] carry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic a;
        logic b;
        logic ci;
        logic esum;
        logic ecarry;
    } vec_t;

    vec_t vecs [8];

    full_adder #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sum       (sum),
        .carry     (carry),
        .in_valid  (in_valid),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .out_valid (out_valid),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic va, input logic vb, input logic vc, input logic vv);
        a = va; b = vb; ci = vc; in_valid = vv;
    endtask

    initial begin
        // Hand-computed truth table, order abc = 000..111.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset for two cycles with a qualified 1+1+1 on the inputs.
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_sum_q",     sum_q,     0);
        chk("rst_carry_q",   carry_q,   0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_carry_cnt", carry_cnt, 0);
        chk("rst_comb_sum",  sum,       1);
        chk("rst_comb_carry", carry,    1);

        // Exhaustive combinational check, 10 time units per vector.
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0);
            #10;
            chk($sformatf("comb_sum[%0d]", i),   sum,   vecs[i].esum);
            chk($sformatf("comb_carry[%0d]", i), carry, vecs[i].ecarry);
        end
        tick();
        chk("idle_cnt", carry_cnt, 0);

        // Registered latency: one qualified 1+0+1.
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat_sum_q",     sum_q,     0);
        chk("lat_carry_q",   carry_q,   1);
        chk("lat_out_valid", out_valid, 1);
        tick();
        chk("hold_out_valid", out_valid, 0);
        chk("hold_sum_q",     sum_q,     0);
        chk("hold_carry_q",   carry_q,   1);
        chk("hold_cnt",       carry_cnt, 1);

        // Counter: restart from 0, stream all 8 qualified.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1);
            tick();
            chk($sformatf("str_sum_q[%0d]", i),   sum_q,     vecs[i].esum);
            chk($sformatf("str_carry_q[%0d]", i), carry_q,   vecs[i].ecarry);
            chk($sformatf("str_valid[%0d]", i),   out_valid, 1);
        end
        chk("cnt_after_stream", carry_cnt, 4);
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0);
            tick();
        end
        chk("cnt_unqualified", carry_cnt, 4);
        chk("unq_out_valid",   out_valid, 0);
        chk("unq_sum_q",       sum_q,     1);
        chk("unq_carry_q",     carry_q,   1);

        // Wrap-around: 256 qualified carries from 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) tick();
        chk("cnt_255", carry_cnt, 255);
        tick();
        chk("cnt_wrap", carry_cnt, 0);

        // Mid-stream reset with in_valid still high.
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_cnt", carry_cnt, 3);
        rst = 1'b1;
        tick();
        chk("mid_sum_q",     sum_q,     0);
        chk("mid_carry_q",   carry_q,   0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_cnt",       carry_cnt, 0);
        chk("mid_comb_carry", carry,    1);
        rst = 1'b0;
        tick();
        chk("post_cnt",       carry_cnt, 1);
        chk("post_out_valid", out_valid, 1);
        chk("post_carry_q",   carry_q,   1);
        chk("post_sum_q",     sum_q,     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
